cr_lz77_comp_tsel: RTL



---
 rtl/cr_lz77_comp_tsel.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cr_lz77_comp_tsel.sv
// Thermometer-to-length token selector at the root of the LZ77 compare tree.
// Two-stage valid/ready pipeline with saturating match/literal statistics.
module cr_lz77_comp_tsel #(
  parameter  int T_WIDTH = 4,
  parameter  int OFF_W   = 4,
  parameter  int MIN_LEN = 3,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = $clog2(T_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [T_WIDTH-1:0] therm_in,
  input  logic [OFF_W-1:0]   offset_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_is_match,
  output logic [LEN_W-1:0]   out_len,
  output logic [OFF_W-1:0]   out_offset,
  input  logic               clr_stats,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]   lit_cnt,
  output logic               bad_therm
);

  localparam logic [LEN_W-1:0] MIN_LEN_L = LEN_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic               r_s1_valid;
  logic [T_WIDTH-1:0] r_s1_therm;
  logic [OFF_W-1:0]   r_s1_off;

  logic               r_s2_valid;
  logic               r_s2_is_match;
  logic [LEN_W-1:0]   r_s2_len;
  logic [OFF_W-1:0]   r_s2_off;

  logic [CNT_W-1:0]   r_match_cnt;
  logic [CNT_W-1:0]   r_lit_cnt;
  logic               r_bad_therm;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_s1_to_s2;
  logic               w_out_fire;
  logic [LEN_W-1:0]   w_len;
  logic               w_contig;
  logic               w_seen_zero;
  logic               w_is_match;

  // The ready chain is combinational through both stages so a full pipe
  // still accepts a token in the same cycle the output drains.
  assign w_s2_adv   = ~r_s2_valid | out_ready;
  assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
  assign w_s1_to_s2 = r_s1_valid & w_s2_adv;
  assign w_out_fire = r_s2_valid & out_ready;
  assign in_ready   = w_s1_adv;

  always_comb begin
    // NOTE: every signal gets a default before the loop, so no path can infer a latch.
    w_len       = '0;
    w_contig    = 1'b1;
    w_seen_zero = 1'b0;
    for (int i = 0; i < T_WIDTH; i++) begin
      if (!w_seen_zero) begin
        if (r_s1_therm[i]) w_len = LEN_W'(i + 1);
        else               w_seen_zero = 1'b1;
      end else if (r_s1_therm[i]) begin
        w_contig = 1'b0;
      end
    end
  end

  assign w_is_match = (w_len >= MIN_LEN_L);

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_therm <= '0;
      r_s1_off   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_therm <= therm_in;
        r_s1_off   <= offset_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_is_match <= 1'b0;
      r_s2_len      <= '0;
      r_s2_off      <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_is_match <= w_is_match;
        r_s2_len      <= w_is_match ? w_len : '0;
        r_s2_off      <= w_is_match ? r_s1_off : '0;
      end
    end
  end

  // Clear wins over a coincident increment or error set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_match_cnt <= '0;
      r_lit_cnt   <= '0;
      r_bad_therm <= 1'b0;
    end else if (clr_stats) begin
      r_match_cnt <= '0;
      r_lit_cnt   <= '0;
      r_bad_therm <= 1'b0;
    end else begin
      if (w_out_fire) begin
        if (r_s2_is_match) begin
          if (r_match_cnt != CNT_MAX) r_match_cnt <= r_match_cnt + CNT_W'(1);
        end else begin
          if (r_lit_cnt != CNT_MAX) r_lit_cnt <= r_lit_cnt + CNT_W'(1);
        end
      end
      if (w_s1_to_s2 && !w_contig) r_bad_therm <= 1'b1;
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_is_match = r_s2_is_match;
  assign out_len      = r_s2_len;
  assign out_offset   = r_s2_off;
  assign match_cnt    = r_match_cnt;
  assign lit_cnt      = r_lit_cnt;
  assign bad_therm    = r_bad_therm;

endmodule
